// File: rtl/led_rom_pkg.sv
// Shared types and ROM word field layout for the LED ROM player.
package led_rom_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

    localparam int ROM_AW  = 8;
    localparam int ROM_DW  = 16;
    localparam int PAT_MSB = 15;
    localparam int PAT_LSB = 8;
    localparam int DUR_MSB = 7;
    localparam int DUR_LSB = 0;

    localparam logic [ROM_DW-1:0] END_MARKER = 16'h0000;

endpackage

// File: rtl/led_tick_div.sv
// Free-running prescaler producing one tick every TICK_DIV enabled cycles.
module led_tick_div #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] tickCnt;

    assign tick = en && !clr && (tickCnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tickCnt <= '0;
        end else if (clr) begin
            tickCnt <= '0;
        end else if (en) begin
            if (tickCnt == LAST) tickCnt <= '0;
            else                 tickCnt <= tickCnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_rom_player.sv
// Fetches pattern/duration words from the LED ROM and plays them on the LEDs.
module led_rom_player
    import led_rom_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter bit LOOP     = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              restart,
    output logic [ROM_AW-1:0] addrRd,
    input  logic [ROM_DW-1:0] dataRd,
    output logic [7:0]        leds,
    output logic              busy,
    output logic              halted,
    output logic              step
);

    state_t            state, stateNext;
    logic [ROM_AW-1:0] pc, pcNext;
    logic [7:0]        ledsReg, ledsNext;
    logic [7:0]        durCnt, durNext;
    logic [7:0]        pattern, duration;
    logic              tick, tickClr;

    assign pattern  = dataRd[PAT_MSB:PAT_LSB];
    assign duration = dataRd[DUR_MSB:DUR_LSB];

    // The prescaler only runs while holding, so every HOLD starts from tick count 0.
    assign tickClr = restart || (state != HOLD);

    led_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (tickClr),
        .en   (en),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= '0;
            ledsReg <= '0;
            durCnt  <= '0;
        end else begin
            state   <= stateNext;
            pc      <= pcNext;
            ledsReg <= ledsNext;
            durCnt  <= durNext;
        end
    end

    always_comb begin
        stateNext = state;
        pcNext    = pc;
        ledsNext  = ledsReg;
        durNext   = durCnt;
        step      = 1'b0;
        if (restart) begin
            stateNext = IDLE;
            pcNext    = '0;
            ledsNext  = '0;
            durNext   = '0;
        end else begin
            case (state)
                IDLE: begin
                    ledsNext = '0;
                    if (en) stateNext = FETCH;
                end
                FETCH: begin
                    if (en) begin
                        if (dataRd != END_MARKER) begin
                            ledsNext  = pattern;
                            durNext   = (duration == 8'd0) ? 8'd1 : duration;
                            pcNext    = pc + 1'b1;
                            stateNext = HOLD;
                        end else if (LOOP && (pc != '0)) begin
                            pcNext = '0;
                        end else begin
                            stateNext = HALT;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        durNext = durCnt - 1'b1;
                        if (durCnt == 8'd1) begin
                            step      = 1'b1;
                            stateNext = FETCH;
                        end
                    end
                end
                HALT: begin
                    stateNext = HALT;
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    assign addrRd = pc;
    assign leds   = ledsReg;
    assign busy   = (state == FETCH) || (state == HOLD);
    assign halted = (state == HALT);

endmodule

// File: tb/tb_led_rom_player.sv
// Randomised and directed bench for led_rom_player, looping and halting builds side by side.
module tb_led_rom_player;

    localparam int TD = 4;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        en      = 1'b0;
    logic        restart = 1'b0;
    logic [15:0] rom [256];

    logic [7:0]  addrRd [2];
    logic [15:0] dataRd [2];
    logic [7:0]  leds   [2];
    logic        busy   [2];
    logic        halted [2];
    logic        step   [2];

    int compared   = 0;
    int mismatched = 0;

    // Timeline model: index 0 loops at the end marker, index 1 halts.
    bit       mIdle [2];
    bit       mHold [2];
    bit       mHalt [2];
    int       mWait [2];
    logic [7:0] mPc   [2];
    logic [7:0] mLeds [2];

    assign dataRd[0] = rom[addrRd[0]];
    assign dataRd[1] = rom[addrRd[1]];

    always #5 clk = ~clk;

    led_rom_player #(.TICK_DIV(TD), .LOOP(1'b1)) dut_loop (
        .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
        .addrRd(addrRd[0]), .dataRd(dataRd[0]), .leds(leds[0]),
        .busy(busy[0]), .halted(halted[0]), .step(step[0])
    );

    led_rom_player #(.TICK_DIV(TD), .LOOP(1'b0)) dut_halt (
        .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
        .addrRd(addrRd[1]), .dataRd(dataRd[1]), .leds(leds[1]),
        .busy(busy[1]), .halted(halted[1]), .step(step[1])
    );

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            mIdle[i] = 1; mHold[i] = 0; mHalt[i] = 0; mWait[i] = 0;
            mPc[i] = 8'd0; mLeds[i] = 8'd0;
        end
    endfunction

    function automatic void model_update();
        logic [15:0] w;
        int d;
        for (int i = 0; i < 2; i++) begin
            if (restart) begin
                mIdle[i] = 1; mHold[i] = 0; mHalt[i] = 0;
                mPc[i] = 8'd0; mLeds[i] = 8'd0;
            end else if (en && !mHalt[i]) begin
                if (mIdle[i]) begin
                    mIdle[i] = 0;
                end else if (mHold[i]) begin
                    mWait[i]--;
                    if (mWait[i] == 0) mHold[i] = 0;
                end else begin
                    w = rom[mPc[i]];
                    if (w != 16'h0000) begin
                        d = int'(w[7:0]);
                        if (d == 0) d = 1;
                        mLeds[i] = w[15:8];
                        mPc[i]   = mPc[i] + 8'd1;
                        mHold[i] = 1;
                        mWait[i] = d * TD;
                    end else if (i == 0 && mPc[i] != 8'd0) begin
                        mPc[i] = 8'd0;
                    end else begin
                        mHalt[i] = 1;
                    end
                end
            end
        end
    endfunction

    function automatic logic [18:0] expv(int i);
        logic s;
        s = mHold[i] && (mWait[i] == 1) && en && !restart;
        return {mLeds[i], mPc[i], !mIdle[i] && !mHalt[i], mHalt[i], s};
    endfunction

    function automatic logic [18:0] obsv(int i);
        return {leds[i], addrRd[i], busy[i], halted[i], step[i]};
    endfunction

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        advance();
        restart = 1'b0;
    endtask

    task automatic load_walking();
        for (int k = 0; k < 256; k++) rom[k] = 16'h0000;
        for (int k = 0; k < 8; k++) rom[k] = {8'(8'h80 >> k), 8'h30};
    endtask

    task automatic test_reset();
        load_walking();
        model_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            compared++;
            if (obsv(i) !== 19'd0) begin
                mismatched++;
                $display("[TB] FAIL reset dut%0d: got %h want %h", i, obsv(i), 19'd0);
            end
        end
    endtask

    task automatic test_walking();
        int firstForty = -1;
        int haltSteps  = 0;
        en = 1'b1;
        rst_n = 1'b1;
        for (int c = 1; c <= 1700; c++) begin
            advance();
            for (int i = 0; i < 2; i++) begin
                compared++;
                if (obsv(i) !== expv(i)) begin
                    mismatched++;
                    $display("[TB] FAIL walk dut%0d cyc%0d: got %h want %h", i, c, obsv(i), expv(i));
                end
            end
            if (firstForty < 0 && leds[0] == 8'h40) firstForty = c;
            if (step[1]) haltSteps++;
        end
        compared++;
        if (firstForty !== 195) begin
            mismatched++;
            $display("[TB] FAIL walk_0x40_cycle: got %0d want 195", firstForty);
        end
        compared++;
        if (haltSteps !== 8) begin
            mismatched++;
            $display("[TB] FAIL walk_step_count: got %0d want 8", haltSteps);
        end
        compared++;
        if ({halted[1], busy[1], leds[1]} !== {1'b1, 1'b0, 8'h01}) begin
            mismatched++;
            $display("[TB] FAIL walk_halt_hold: got %h want %h", {halted[1], busy[1], leds[1]}, {1'b1, 1'b0, 8'h01});
        end
    endtask

    task automatic test_restart();
        pulse_restart();
        compared++;
        if ({leds[1], addrRd[1], halted[1]} !== 17'd0) begin
            mismatched++;
            $display("[TB] FAIL restart_clear: got %h want %h", {leds[1], addrRd[1], halted[1]}, 17'd0);
        end
        for (int c = 1; c <= 10; c++) begin
            advance();
            for (int i = 0; i < 2; i++) begin
                compared++;
                if (obsv(i) !== expv(i)) begin
                    mismatched++;
                    $display("[TB] FAIL replay dut%0d cyc%0d: got %h want %h", i, c, obsv(i), expv(i));
                end
            end
        end
    endtask

    task automatic test_en_freeze();
        int firstTen = -1;
        en = 1'b1;
        pulse_restart();
        for (int c = 1; c <= 700; c++) begin
            en = (c > 400 && c <= 450) ? 1'b0 : 1'b1;
            advance();
            for (int i = 0; i < 2; i++) begin
                compared++;
                if (obsv(i) !== expv(i)) begin
                    mismatched++;
                    $display("[TB] FAIL freeze dut%0d cyc%0d: got %h want %h", i, c, obsv(i), expv(i));
                end
            end
            if (c == 450) begin
                compared++;
                if (leds[0] !== 8'h20) begin
                    mismatched++;
                    $display("[TB] FAIL freeze_hold_leds: got %h want %h", leds[0], 8'h20);
                end
            end
            if (firstTen < 0 && leds[0] == 8'h10) firstTen = c;
        end
        compared++;
        if (firstTen !== 631) begin
            mismatched++;
            $display("[TB] FAIL freeze_delay: got %0d want 631", firstTen);
        end
    endtask

    task automatic test_clamp();
        int steps [2] = '{0, 0};
        for (int k = 0; k < 256; k++) rom[k] = 16'h0000;
        rom[0] = 16'hA500;
        en = 1'b1;
        pulse_restart();
        for (int c = 1; c <= 30; c++) begin
            advance();
            for (int i = 0; i < 2; i++) begin
                compared++;
                if (obsv(i) !== expv(i)) begin
                    mismatched++;
                    $display("[TB] FAIL clamp dut%0d cyc%0d: got %h want %h", i, c, obsv(i), expv(i));
                end
                if (step[i]) steps[i]++;
            end
        end
        compared++;
        if (steps[0] !== 5) begin
            mismatched++;
            $display("[TB] FAIL clamp_loop_steps: got %0d want 5", steps[0]);
        end
        compared++;
        if (steps[1] !== 1 || leds[1] !== 8'hA5) begin
            mismatched++;
            $display("[TB] FAIL clamp_halt: got steps %0d leds %h want 1 a5", steps[1], leds[1]);
        end
    endtask

    task automatic test_empty();
        for (int k = 0; k < 256; k++) rom[k] = 16'h0000;
        en = 1'b1;
        pulse_restart();
        for (int c = 1; c <= 5; c++) begin
            advance();
            for (int i = 0; i < 2; i++) begin
                compared++;
                if (obsv(i) !== expv(i)) begin
                    mismatched++;
                    $display("[TB] FAIL empty dut%0d cyc%0d: got %h want %h", i, c, obsv(i), expv(i));
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            compared++;
            if ({halted[i], leds[i]} !== {1'b1, 8'h00}) begin
                mismatched++;
                $display("[TB] FAIL empty_halt dut%0d: got %h want %h", i, {halted[i], leds[i]}, {1'b1, 8'h00});
            end
        end
    endtask

    task automatic test_async_reset();
        load_walking();
        en = 1'b1;
        pulse_restart();
        for (int c = 1; c <= 100; c++) advance();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            compared++;
            if ({leds[i], addrRd[i], halted[i]} !== 17'd0) begin
                mismatched++;
                $display("[TB] FAIL async_reset dut%0d: got %h want %h", i, {leds[i], addrRd[i], halted[i]}, 17'd0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            advance();
            for (int i = 0; i < 2; i++) begin
                compared++;
                if (obsv(i) !== expv(i)) begin
                    mismatched++;
                    $display("[TB] FAIL post_reset dut%0d cyc%0d: got %h want %h", i, c, obsv(i), expv(i));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 256; k++) rom[k] = 16'h0000;
        for (int k = 0; k < 6; k++) rom[k] = {8'($urandom), 8'($urandom_range(0, 3))};
        pulse_restart();
        for (int c = 1; c <= 800; c++) begin
            en      = ($urandom_range(0, 3) != 0);
            restart = ($urandom_range(0, 99) == 0);
            advance();
            for (int i = 0; i < 2; i++) begin
                compared++;
                if (obsv(i) !== expv(i)) begin
                    mismatched++;
                    $display("[TB] FAIL random dut%0d cyc%0d: got %h want %h", i, c, obsv(i), expv(i));
                end
            end
        end
        restart = 1'b0;
    endtask

    initial begin
        test_reset();
        test_walking();
        test_restart();
        test_en_freeze();
        test_clamp();
        test_empty();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/led_rom_player.md
Name: led_rom_player

Overview:
- Sequencer that fetches the 16-bit pattern program from the LED ROM's read port and plays it out on the board LEDs.
- Each ROM word has two fields:
  - dataRd[15:8] is the LED pattern.
  - dataRd[7:0] is the hold duration, in ticks.
- The all-zero word is the end-of-program marker.
- The block sits between the LED ROM (combinational read) and the LED pins. It is the reader/consumer end of the ROM's addrRd/dataRd interface.

Parameters:
- TICK_DIV, 4, clock cycles per duration tick (>=1). Board builds override this (e.g. 1_000_000).
- LOOP, 1, 1 = wrap to address 0 at the end marker; 0 = halt at the end marker.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run enable. 0 freezes playback (counters and pc hold, LEDs hold).
- restart  input  1  synchronous pulse that returns the block to IDLE with pc=0.
- addrRd  output  8  ROM read address; equals the pc register.
- dataRd  input  16  ROM read data. Combinational, valid in the same cycle as addrRd.
- leds  output  8  registered LED pattern.
- busy  output  1  high in FETCH or HOLD.
- halted  output  1  high in HALT.
- step  output  1  one-cycle pulse on the last cycle of each HOLD.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, pc=0, leds=0, tickCnt=0, durCnt=0.
  - busy=0, halted=0, step=0.
- restart=1 has priority over everything except reset. Next state is IDLE with pc=0, leds=0, counters=0.
- IDLE: leds=0. If en=1, go to FETCH next cycle.
- FETCH (exactly one cycle; dataRd sampled at addrRd=pc):
  - dataRd != 0:
    - leds <= dataRd[15:8].
    - durCnt <= (dataRd[7:0]==0) ? 1 : dataRd[7:0]. A zero duration is clamped to 1 tick.
    - tickCnt <= 0.
    - pc <= pc+1, with 8-bit wrap (255 -> 0).
    - Go to HOLD.
  - dataRd == 0 with LOOP=1 and pc != 0: pc <= 0, stay in FETCH, leds unchanged (one bubble cycle).
  - dataRd == 0 with pc==0 (empty program), or with LOOP=0: go to HALT, leds unchanged.
  - en=0 while in FETCH: no sample, no state change.
- HOLD (only advances when en=1):
  - tickCnt increments each cycle.
  - When tickCnt==TICK_DIV-1: tickCnt <= 0 and durCnt <= durCnt-1.
  - If that terminal tick also has durCnt==1: step=1 that cycle, next state FETCH.
  - en=0: tickCnt and durCnt hold; step stays 0.
- HALT: leds keep the last pattern, halted=1. Only restart or reset leaves HALT.
- Timing:
  - The pattern from word k appears on leds the cycle after its FETCH.
  - It holds for exactly max(dur,1)*TICK_DIV cycles of en=1, plus the 1-cycle FETCH of the next word, during which leds are unchanged.
  - Per-entry period = max(dur,1)*TICK_DIV + 1 cycles.
- Widths:
  - tickCnt is $clog2(TICK_DIV) bits, minimum 1.
  - durCnt is 8 bits and never underflows, because of the clamp.
- Reset asserted mid-HOLD: all outputs return to reset values immediately (async).

Decomposition:
- Shared package led_rom_pkg holds:
  - state enum {IDLE, FETCH, HOLD, HALT};
  - field constants PAT_MSB=15, PAT_LSB=8, DUR_MSB=7, DUR_LSB=0;
  - END_MARKER=16'h0000;
  - ROM_AW=8, ROM_DW=16.
- One sub-module, led_tick_div:
  - parameterised by TICK_DIV;
  - inputs clk, rst_n, clr, en;
  - output tick (1 on the terminal count).
- The FSM, pc and durCnt stay in led_rom_player.

Test Plan:
- Default ROM program (8 walking-one words, dur 0x30), TICK_DIV=4, en=1 after reset:
  - leds goes 0x80 at cycle 2, 0x40 at cycle 195 (192+1 later), ... 0x01.
  - At addr 8 the end marker causes pc->0 and a 1-cycle bubble, then leds returns to 0x80. step pulses 8 times per pass.
- Same program with LOOP=0: after the 0x01 entry, halted=1, busy=0, leds holds 0x01 indefinitely. A restart pulse gives leds=0 and pc=0, then replay.
- en deasserted for 50 cycles mid-HOLD of word 2: leds stays 0x20, and the next transition is delayed by exactly 50 cycles.
- ROM word 16'hA500 (dur=0) at addr 0, followed by the end marker: 0xA5 is held for exactly TICK_DIV cycles (clamp), then loops.
- All-zero ROM: the first FETCH sees the end marker at pc=0, giving HALT after 1 cycle; leds=0 and halted=1.
- rst_n pulsed low asynchronously (between clock edges) mid-HOLD: leds=0, addrRd=0 and halted=0 immediately. Playback restarts from addr 0 when en=1.
